// File: rtl/sched_pkg.sv
// Shared definitions for the fine-grained multithreading fetch scheduler:
// default thread count / id width and the per-thread context state encoding.
package sched_pkg;

    localparam int DEF_NUM_THREADS  = 8;
    localparam int DEF_BITS_THREADS = 3;

    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_RUN     = 2'd1,
        T_BLOCKED = 2'd2
    } thread_state_t;

    // Next context state for one thread. Requests are prioritised
    // kill > start > block_clr > block_set; a higher-priority request that
    // is present masks the lower ones even when it has no effect itself.
    function automatic thread_state_t next_thread_state(
        input thread_state_t cur,
        input logic          kill,
        input logic          start,
        input logic          clr,
        input logic          set
    );
        next_thread_state = cur;
        if (kill) begin
            next_thread_state = T_IDLE;
        end else if (start) begin
            if (cur == T_IDLE) next_thread_state = T_RUN;
        end else if (clr) begin
            if (cur == T_BLOCKED) next_thread_state = T_RUN;
        end else if (set) begin
            if (cur == T_RUN) next_thread_state = T_BLOCKED;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating find-first: returns the first set bit of req, searching upward
// from index start with wrap-around. grant_valid is low when req is empty.
module rr_arbiter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] grant,
    output logic         grant_valid
);

    // Scan all N positions once, starting at the pointer, keep the first hit.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned; otherwise synthesis would infer a latch.
        int         idx;
        logic [W-1:0] idx_w;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        idx_w       = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start) + k;
            if (idx >= N) idx = idx - N;
            idx_w = W'(idx);
            if (!grant_valid && req[idx_w]) begin
                grant       = idx_w;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Per-thread context state machine plus registered fetch-slot selection.
// Default build: work-conserving round-robin that skips non-runnable threads.
// Define SCHED_STRICT_BARREL_EN for a strict barrel: tid_f steps by one every
// non-stalled edge and fetch_valid reflects whether that thread is runnable.
module thread_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_THREADS  = DEF_NUM_THREADS,
    parameter int BITS_THREADS = DEF_BITS_THREADS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    thread_start,
    input  logic [BITS_THREADS-1:0] start_tid,
    input  logic                    thread_kill,
    input  logic [BITS_THREADS-1:0] kill_tid,
    input  logic [NUM_THREADS-1:0]  block_set,
    input  logic [NUM_THREADS-1:0]  block_clr,
    input  logic                    stall,
    output logic [BITS_THREADS-1:0] tid_f,
    output logic                    fetch_valid,
    output logic                    en_fd,
    output logic                    clr_fd,
    output logic [NUM_THREADS-1:0]  active_mask
);

    thread_state_t            state_q [NUM_THREADS];
    thread_state_t            state_d [NUM_THREADS];
    logic [NUM_THREADS-1:0]   runnable;

    // Next context state per thread, plus runnable/active views of the
    // current state (changes take effect for selection one edge later).
    always_comb begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            state_d[i] = next_thread_state(
                state_q[i],
                thread_kill  && (kill_tid  == BITS_THREADS'(i)),
                thread_start && (start_tid == BITS_THREADS'(i)),
                block_clr[i],
                block_set[i]);
            runnable[i]    = (state_q[i] == T_RUN);
            active_mask[i] = (state_q[i] != T_IDLE);
        end
    end

    // Thread context registers; updates continue regardless of stall.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the state array is control state, not a data store, so every
        // entry is reset; an abort must leave all contexts IDLE.
        if (!rst_n) begin
            for (int i = 0; i < NUM_THREADS; i++) state_q[i] <= T_IDLE;
        end else begin
            // NOTE: non-blocking assignments for all sequential state so every
            // register samples pre-edge values regardless of statement order.
            for (int i = 0; i < NUM_THREADS; i++) state_q[i] <= state_d[i];
        end
    end

`ifdef SCHED_STRICT_BARREL_EN
    logic [BITS_THREADS-1:0] barrel_next;

    assign barrel_next = (tid_f == BITS_THREADS'(NUM_THREADS - 1))
                       ? '0 : tid_f + BITS_THREADS'(1);

    // Strict barrel: step the slot every non-stalled edge; during a stall hold
    // the slot but drop it if its thread is killed or blocked meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tid_f       <= '0;
            fetch_valid <= 1'b0;
        end else if (stall) begin
            fetch_valid <= fetch_valid && (state_d[tid_f] == T_RUN);
        end else begin
            tid_f       <= barrel_next;
            fetch_valid <= runnable[barrel_next];
        end
    end
`else
    logic [BITS_THREADS-1:0] search_ptr;
    logic [BITS_THREADS-1:0] grant;
    logic                    grant_valid;
    logic [BITS_THREADS-1:0] grant_next;

    rr_arbiter #(
        .N (NUM_THREADS),
        .W (BITS_THREADS)
    ) u_rr_arbiter (
        .req         (runnable),
        .start       (search_ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign grant_next = (grant == BITS_THREADS'(NUM_THREADS - 1))
                      ? '0 : grant + BITS_THREADS'(1);

    // Work-conserving selection: take the next runnable thread after the
    // last one fetched; with none runnable hold tid_f and the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tid_f       <= '0;
            fetch_valid <= 1'b0;
            search_ptr  <= '0;
        end else if (stall) begin
            fetch_valid <= fetch_valid && (state_d[tid_f] == T_RUN);
        end else if (grant_valid) begin
            tid_f       <= grant;
            fetch_valid <= 1'b1;
            search_ptr  <= grant_next;
        end else begin
            fetch_valid <= 1'b0;
        end
    end
`endif

    assign en_fd  = stall;
    assign clr_fd = ~fetch_valid & ~stall;

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler: directed scenarios followed by a
// randomized phase, all compared against a behavioural model of the thread
// rules and fetch-slot policy. Follows SCHED_STRICT_BARREL_EN if defined.
module tb_thread_scheduler;

    localparam int N = 8;
    localparam int B = 3;

    typedef enum int {M_IDLE, M_RUN, M_BLOCKED} mstate_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         thread_start;
    logic [B-1:0] start_tid;
    logic         thread_kill;
    logic [B-1:0] kill_tid;
    logic [N-1:0] block_set;
    logic [N-1:0] block_clr;
    logic         stall;
    logic [B-1:0] tid_f;
    logic         fetch_valid;
    logic         en_fd;
    logic         clr_fd;
    logic [N-1:0] active_mask;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    mstate_t ms [N];
    int      m_tid;
    int      m_ptr;
    bit      m_valid;

    always #5 clk = ~clk;

    thread_scheduler #(.NUM_THREADS(N), .BITS_THREADS(B)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .thread_start (thread_start),
        .start_tid    (start_tid),
        .thread_kill  (thread_kill),
        .kill_tid     (kill_tid),
        .block_set    (block_set),
        .block_clr    (block_clr),
        .stall        (stall),
        .tid_f        (tid_f),
        .fetch_valid  (fetch_valid),
        .en_fd        (en_fd),
        .clr_fd       (clr_fd),
        .active_mask  (active_mask)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < N; t++) ms[t] = M_IDLE;
        m_tid   = 0;
        m_ptr   = 0;
        m_valid = 1'b0;
    endtask

    function automatic logic [N-1:0] model_mask();
        logic [N-1:0] m;
        for (int t = 0; t < N; t++) m[t] = (ms[t] != M_IDLE);
        return m;
    endfunction

    // One rising edge of the reference: thread rules, then slot choice from
    // the pre-edge states.
    task automatic model_edge();
        mstate_t ns [N];
        bit      found;
        int      idx;
        for (int t = 0; t < N; t++) begin
            ns[t] = ms[t];
            if (thread_kill && int'(kill_tid) == t)
                ns[t] = M_IDLE;
            else if (thread_start && int'(start_tid) == t) begin
                if (ms[t] == M_IDLE) ns[t] = M_RUN;
            end else if (block_clr[t]) begin
                if (ms[t] == M_BLOCKED) ns[t] = M_RUN;
            end else if (block_set[t]) begin
                if (ms[t] == M_RUN) ns[t] = M_BLOCKED;
            end
        end
        if (stall) begin
            m_valid = m_valid && (ns[m_tid] == M_RUN);
        end else begin
`ifdef SCHED_STRICT_BARREL_EN
            m_tid   = (m_tid + 1) % N;
            m_valid = (ms[m_tid] == M_RUN);
`else
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && ms[idx] == M_RUN) begin
                    found = 1'b1;
                    m_tid = idx;
                    m_ptr = (idx + 1) % N;
                end
            end
            m_valid = found;
`endif
        end
        for (int t = 0; t < N; t++) ms[t] = ns[t];
    endtask

    task automatic check_all(input string tag);
        check({tag, ".tid_f"},       32'(tid_f),       32'(m_tid));
        check({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(m_valid));
        check({tag, ".active_mask"}, 32'(active_mask), 32'(model_mask()));
        check({tag, ".en_fd"},       32'(en_fd),       32'(stall));
        check({tag, ".clr_fd"},      32'(clr_fd),      32'(!m_valid && !stall));
    endtask

    // Drive one cycle of inputs at the falling edge, step the model at the
    // rising edge and compare shortly after it.
    task automatic cyc(input string tag, input logic st, input int stid,
                       input logic kl, input int ktid,
                       input logic [N-1:0] bs, input logic [N-1:0] bc,
                       input logic stl);
        @(negedge clk);
        thread_start = st;
        start_tid    = B'(stid);
        thread_kill  = kl;
        kill_tid     = B'(ktid);
        block_set    = bs;
        block_clr    = bc;
        stall        = stl;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        repeat (n) cyc(tag, 1'b0, 0, 1'b0, 0, '0, '0, 1'b0);
    endtask

    task automatic start_t(input string tag, input int t);
        cyc(tag, 1'b1, t, 1'b0, 0, '0, '0, 1'b0);
    endtask

    task automatic kill_t(input string tag, input int t);
        cyc(tag, 1'b0, 0, 1'b1, t, '0, '0, 1'b0);
    endtask

    initial begin
        bit ok;
        int seq_exp [6];

        rst_n        = 1'b0;
        thread_start = 1'b0;
        start_tid    = '0;
        thread_kill  = 1'b0;
        kill_tid     = '0;
        block_set    = '0;
        block_clr    = '0;
        stall        = 1'b0;
        model_reset();

        // Reset state.
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_reset", 2);

        // Start 0, 2, 5 on consecutive cycles.
        seq_exp = '{0, 2, 5, 0, 2, 5};
        start_t("start0", 0);
        start_t("start2", 2);
`ifndef SCHED_STRICT_BARREL_EN
        check("seq0.tid", 32'(tid_f), 32'(seq_exp[0]));
        check("seq0.valid", 32'(fetch_valid), 32'd1);
`endif
        start_t("start5", 5);
`ifndef SCHED_STRICT_BARREL_EN
        check("seq1.tid", 32'(tid_f), 32'(seq_exp[1]));
`endif
        for (int i = 2; i < 6; i++) begin
            idle("rr", 1);
`ifndef SCHED_STRICT_BARREL_EN
            check($sformatf("seq%0d.tid", i), 32'(tid_f), 32'(seq_exp[i]));
            check($sformatf("seq%0d.valid", i), 32'(fetch_valid), 32'd1);
`endif
        end
        kill_t("kill0", 0);
        kill_t("kill2", 2);
        kill_t("kill5", 5);
        idle("drain", 2);

        // Only tid 3 running, then blocked and woken.
        start_t("start3", 3);
        idle("run3", 3);
        cyc("block3", 1'b0, 0, 1'b0, 0, 8'h08, '0, 1'b0);
        idle("blocked3", 3);
        check("blocked.valid", 32'(fetch_valid), 32'd0);
        check("blocked.clr_fd", 32'(clr_fd), 32'd1);
        cyc("wake3", 1'b0, 0, 1'b0, 0, '0, 8'h08, 1'b0);
        idle("resume3", 2);
        kill_t("kill3", 3);
        idle("drain", 2);

        // Start and kill of tid 4 in the same cycle.
        cyc("startkill4", 1'b1, 4, 1'b1, 4, '0, '0, 1'b0);
        check("sk4.active", 32'(active_mask[4]), 32'd0);
        idle("sk4_after", 2);
        check("sk4.active_later", 32'(active_mask[4]), 32'd0);

        // Stall with tid_f on thread 2, kill it mid-stall.
        start_t("start2b", 2);
        ok = 1'b0;
        for (int i = 0; i < 2 * N && !ok; i++) begin
            idle("seek2", 1);
            ok = (m_tid == 2) && m_valid;
        end
        check("seek2.reached", 32'(ok), 32'd1);
        cyc("stall_a", 1'b0, 0, 1'b0, 0, '0, '0, 1'b1);
        check("stall_a.tid", 32'(tid_f), 32'd2);
        check("stall_a.en_fd", 32'(en_fd), 32'd1);
        check("stall_a.clr_fd", 32'(clr_fd), 32'd0);
        cyc("stall_kill", 1'b0, 0, 1'b1, 2, '0, '0, 1'b1);
        check("stall_kill.valid", 32'(fetch_valid), 32'd0);
        check("stall_kill.clr_fd", 32'(clr_fd), 32'd0);
        cyc("stall_c", 1'b0, 0, 1'b0, 0, '0, '0, 1'b1);
        check("stall_c.tid", 32'(tid_f), 32'd2);
        idle("unstall", 1);
        check("unstall.clr_fd", 32'(clr_fd), 32'd1);

`ifdef SCHED_STRICT_BARREL_EN
        // Barrel with only 1 and 6 running.
        start_t("b_start1", 1);
        start_t("b_start6", 6);
        for (int i = 0; i < 2 * N; i++) begin
            idle("barrel", 1);
            check("barrel.valid_rule", 32'(fetch_valid),
                  32'(tid_f == 3'd1 || tid_f == 3'd6));
        end
        kill_t("b_kill1", 1);
        kill_t("b_kill6", 6);
`endif

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            cyc("rand",
                1'b0 != ($urandom_range(0, 2) == 0), $urandom_range(0, N - 1),
                1'b0 != ($urandom_range(0, 7) == 0), $urandom_range(0, N - 1),
                N'($urandom & $urandom & $urandom),
                N'($urandom & $urandom),
                1'b0 != ($urandom_range(0, 5) == 0));
        end

        // Start all 8, then reset mid-cycle.
        for (int t = 0; t < N; t++) start_t("start_all", t);
        idle("run_all", 3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midreset.tid", 32'(tid_f), 32'd0);
        check("midreset.valid", 32'(fetch_valid), 32'd0);
        check("midreset.mask", 32'(active_mask), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle("after_reset", 3);
        check("after_reset.mask", 32'(active_mask), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
